// File: rtl/pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_pkg : shared types and constants for the pipe column scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SPACE  = 2'd1,
        ST_PIPE   = 2'd2,
        ST_FROZEN = 2'd3
    } state_t;

    localparam int              ROWS      = 16;
    // Feedback taps 15,13,12,10
    localparam logic [ROWS-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [ROWS-1:0] EMPTY_COL = 16'h0000;

    // Folds a raw nibble onto gap rows 1..12 so rows 0 and 15 stay lit.
    function automatic logic [3:0] gap_from_raw(input logic [3:0] raw);
        return (raw < 4'd12) ? (raw + 4'd1) : (raw - 4'd11);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_lfsr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_lfsr : 16-bit Fibonacci LFSR, seed loaded on reset, advance on enable
// Rev 1.0
// ---------------------------------------------------------------------------
module pipe_lfsr
    import pipe_pkg::*;
#(
    parameter logic [ROWS-1:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       advance,
    output logic [3:0] raw
);

    logic [ROWS-1:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else if (advance) begin
            lfsr <= {lfsr[ROWS-2:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign raw = lfsr[3:0];

endmodule
`default_nettype wire

// File: rtl/pipe_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_scheduler : emits empty/pipe column patterns for the pipe shift register
// Rev 1.0
// ---------------------------------------------------------------------------
module pipe_scheduler
    import pipe_pkg::*;
#(
    parameter int              SPACING = 6,
    parameter int              PIPE_W  = 2,
    parameter int              GAP_H   = 3,
    parameter logic [ROWS-1:0] SEED    = 16'hACE1
) (
    input  logic            clk,
    input  logic            RST,
    input  logic            start,
    input  logic            tick,
    input  logic            Over,
    output logic [ROWS-1:0] NR,
    output logic            col_is_pipe,
    output logic [3:0]      gap_pos,
    output logic            pipe_passed
);

    localparam int CNT_MAX = (SPACING > PIPE_W) ? SPACING : PIPE_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [ROWS-1:0]   nr_nx;
    logic              col_nx;
    logic [3:0]        gap_nx;
    logic              pass_nx;
    logic              lfsr_adv;
    logic [3:0]        lfsr_raw;

    function automatic logic [ROWS-1:0] pipe_pattern(input logic [3:0] lo);
        logic [ROWS-1:0] p;
        p = '1;
        for (int i = 0; i < GAP_H; i++) begin
            p[lo + 4'(i)] = 1'b0;
        end
        return p;
    endfunction

    pipe_lfsr #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst_n   (RST),
        .advance (lfsr_adv),
        .raw     (lfsr_raw)
    );

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            NR          <= EMPTY_COL;
            col_is_pipe <= 1'b0;
            gap_pos     <= 4'd0;
            pipe_passed <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            NR          <= nr_nx;
            col_is_pipe <= col_nx;
            gap_pos     <= gap_nx;
            pipe_passed <= pass_nx;
        end
    end

    // gap_pos doubles as the latched gap row used for every column of a pipe.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        nr_nx    = NR;
        col_nx   = col_is_pipe;
        gap_nx   = gap_pos;
        pass_nx  = 1'b0;
        lfsr_adv = 1'b0;
        if (Over) begin
            if (state != ST_IDLE) begin
                state_nx = ST_FROZEN;
            end
        end else begin
            case (state)
                ST_IDLE, ST_FROZEN: begin
                    if (start) begin
                        state_nx = ST_SPACE;
                        cnt_nx   = '0;
                        nr_nx    = EMPTY_COL;
                        col_nx   = 1'b0;
                    end
                end
                ST_SPACE: begin
                    if (tick) begin
                        nr_nx  = EMPTY_COL;
                        col_nx = 1'b0;
                        if (cnt == CNT_W'(SPACING - 1)) begin
                            gap_nx   = gap_from_raw(lfsr_raw);
                            lfsr_adv = 1'b1;
                            cnt_nx   = '0;
                            state_nx = ST_PIPE;
                        end else begin
                            cnt_nx = cnt + 1'b1;
                        end
                    end
                end
                ST_PIPE: begin
                    if (tick) begin
                        nr_nx  = pipe_pattern(gap_pos);
                        col_nx = 1'b1;
                        if (cnt == CNT_W'(PIPE_W - 1)) begin
                            pass_nx  = 1'b1;
                            cnt_nx   = '0;
                            state_nx = ST_SPACE;
                        end else begin
                            cnt_nx = cnt + 1'b1;
                        end
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
